// File: rtl/idu_exu_pipe.sv
// idu_exu_pipe: ID->EX pipeline register for the RV32I core.
// Picks each source operand from the register file or a forwarding path,
// detects load-use hazards (issuing bubbles while they hold) and registers
// the selected operands plus decoded control toward EXU under valid/ready
// with flush.
// Optional feature macro: IDU_EXU_STALL_CNT_EN adds a 32-bit stall_cnt
// output counting cycles spent in the STALL state.
module idu_exu_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            IDU_valid,
  output logic            IDU_ready,
  input  logic [XLEN-1:0] IDU_pc,
  input  logic [31:0]     IDU_inst,
  input  logic [4:0]      IDU_rs1,
  input  logic [4:0]      IDU_rs2,
  input  logic [4:0]      IDU_rd,
  input  logic            IDU_rs1_used,
  input  logic            IDU_rs2_used,
  input  logic            IDU_R_Wen,
  input  logic            IDU_mem_ren,
  input  logic            IDU_mem_wen,
  input  logic [XLEN-1:0] IDU_imm,
  input  logic [2:0]      IDU_rs1_choice,
  input  logic [2:0]      IDU_rs2_choice,
  input  logic [XLEN-1:0] RF_rdata1,
  input  logic [XLEN-1:0] RF_rdata2,
  input  logic [XLEN-1:0] FWD_exu,
  input  logic [XLEN-1:0] FWD_mem,
  input  logic [XLEN-1:0] FWD_mem2,
  input  logic [XLEN-1:0] FWD_wb,
  input  logic [XLEN-1:0] FWD_mem_pipe,
  input  logic [4:0]      MEM_rd,
  input  logic            MEM_valid,
  input  logic            MEM_R_Wen,
  input  logic            MEM_mem_ren,
  input  logic            EXU_ready,
  output logic            EXU_valid,
  output logic [XLEN-1:0] EXU_pc,
  output logic [31:0]     EXU_inst,
  output logic [XLEN-1:0] EXU_src1,
  output logic [XLEN-1:0] EXU_src2,
  output logic [XLEN-1:0] EXU_imm,
  output logic [4:0]      EXU_rd,
  output logic            EXU_R_Wen,
  output logic            EXU_mem_ren,
  output logic            EXU_mem_wen,
  output logic            load_use_stall
`ifdef IDU_EXU_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t          state;
  logic            lu;
  logic            adv;
  logic            accept;
  logic [XLEN-1:0] src1_p0;
  logic [XLEN-1:0] src2_p0;

  // Forwarding mux: codes 110/111 are unused and fall back to the RF value.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [2:0]      choice,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] exu,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] mem2,
    input logic [XLEN-1:0] wb,
    input logic [XLEN-1:0] mem_pipe
  );
    case (choice)
      3'b001:  sel_operand = exu;
      3'b010:  sel_operand = mem;
      3'b011:  sel_operand = mem2;
      3'b100:  sel_operand = wb;
      3'b101:  sel_operand = mem_pipe;
      default: sel_operand = rf;
    endcase
  endfunction

  assign src1_p0 = sel_operand(IDU_rs1_choice, RF_rdata1, FWD_exu, FWD_mem,
                               FWD_mem2, FWD_wb, FWD_mem_pipe);
  assign src2_p0 = sel_operand(IDU_rs2_choice, RF_rdata2, FWD_exu, FWD_mem,
                               FWD_mem2, FWD_wb, FWD_mem_pipe);

  // A load in MEM whose result is read by the ID instruction cannot be
  // forwarded yet; the ID beat must wait one cycle for the MEM_PIPE path.
  assign lu = IDU_valid && MEM_valid && MEM_R_Wen && MEM_mem_ren &&
              (MEM_rd != 5'd0) &&
              ((IDU_rs1_used && (MEM_rd == IDU_rs1)) ||
               (IDU_rs2_used && (MEM_rd == IDU_rs2)));

  assign load_use_stall = lu;
  assign adv            = !EXU_valid || EXU_ready;
  // rst_n gating keeps IDU_ready low through the reset cycle itself.
  assign IDU_ready      = rst_n && adv && !lu && !flush;
  assign accept         = IDU_valid && IDU_ready;

  // ---- ID -> EX register boundary ----
  // Capture operands at accept; a held entry never re-evaluates forwarding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      EXU_valid   <= 1'b0;
      EXU_pc      <= '0;
      EXU_inst    <= '0;
      EXU_src1    <= '0;
      EXU_src2    <= '0;
      EXU_imm     <= '0;
      EXU_rd      <= '0;
      EXU_R_Wen   <= 1'b0;
      EXU_mem_ren <= 1'b0;
      EXU_mem_wen <= 1'b0;
    end else if (flush) begin
      EXU_valid <= 1'b0;
    end else if (accept) begin
      EXU_valid   <= 1'b1;
      EXU_pc      <= IDU_pc;
      EXU_inst    <= IDU_inst;
      EXU_src1    <= src1_p0;
      EXU_src2    <= src2_p0;
      EXU_imm     <= IDU_imm;
      EXU_rd      <= IDU_rd;
      EXU_R_Wen   <= IDU_R_Wen;
      EXU_mem_ren <= IDU_mem_ren;
      EXU_mem_wen <= IDU_mem_wen;
    end else if (adv) begin
      EXU_valid <= 1'b0;
    end
  end

  // Bubble-issue FSM: STALL marks cycles where a load-use bubble went out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else if (flush) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (lu && adv) state <= STALL;
        STALL:   if (!lu) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef IDU_EXU_STALL_CNT_EN
  // Free-running STALL-cycle counter; wraps naturally, survives flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == STALL) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
